// File: rtl/ahb_master_bridge.sv
// CPU-to-AHB master bridge with a posted-write FIFO, a single outstanding read,
// and RETRY/SPLIT re-arbitration that gives up after a bounded number of tries.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_master_bridge #(
    parameter logic [3:0] SEL        = 4'h1,
    parameter int         DW         = 32,
    parameter int         WBUF_DEPTH = 4,
    parameter int         MAX_RETRY  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic                       cpu_write,
    input  logic [2:0]                 cpu_size,
    input  logic [31:0]                cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    output logic                       cpu_ack,
    output logic                       cpu_rvalid,
    output logic [DW-1:0]              cpu_rdata,
    output logic                       cpu_err,
    output logic                       wbuf_empty,
    output logic                       HReq,
    output logic                       HLock,
    output logic [31:0]                HAddress,
    output logic [`AHB_TRANS_BITS-1:0] HTrans,
    output logic [`AHB_SIZE_BITS-1:0]  HSize,
    output logic                       HWrite,
    output logic [DW-1:0]              HWrite_data,
    input  logic [DW-1:0]              HRead_data,
    input  logic [1:0]                 HResp,
    input  logic                       HReady,
    input  logic                       HGrant
);
    localparam int AW    = $clog2(WBUF_DEPTH);
    localparam int MAXSZ = $clog2(DW / 8);
    localparam int RW    = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ADDR, S_DATA} state_t;
    state_t state, state_nx;

    logic [27:0]   f_addr [WBUF_DEPTH];
    logic [2:0]    f_size [WBUF_DEPTH];
    logic [DW-1:0] f_data [WBUF_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          f_empty, f_full, push, pop;

    logic          rd_pend;
    logic [27:0]   rd_addr;
    logic [2:0]    rd_size;
    logic          x_write;
    logic [27:0]   x_addr;
    logic [2:0]    x_size;
    logic [DW-1:0] x_data;
    logic [RW-1:0] retry_cnt;
    logic          rvalid_q, err_q;
    logic [DW-1:0] rdata_q;
    logic          size_bad, start, done_ok, done_err, retry;
    logic          unused_addr_hi;

    // The region nibble always comes from SEL, so the CPU's top bits are dropped.
    assign unused_addr_hi = ^cpu_addr[31:28];

    assign f_empty  = (wr_ptr == rd_ptr);
    assign f_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign size_bad = (cpu_size > 3'(MAXSZ));
    assign cpu_ack  = rst & cpu_req & ~rd_pend & (~cpu_write | ~f_full);
    assign push     = cpu_ack & cpu_write & ~size_bad;
    assign start    = (state == S_IDLE) & (~f_empty | rd_pend);
    assign pop      = (done_ok | done_err) & x_write;

    always_comb begin
        state_nx = state;
        done_ok  = 1'b0;
        done_err = 1'b0;
        retry    = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_ARB;
            S_ARB:  if (HGrant && HReady) state_nx = S_ADDR;
            S_ADDR: if (HReady) state_nx = S_DATA;
            S_DATA: begin
                if (HReady) begin
                    unique case (1'b1)
                        (HResp == 2'b00): done_ok = 1'b1;
                        (HResp == 2'b01): done_err = 1'b1;
                        default: begin
                            if (retry_cnt == RW'(MAX_RETRY)) done_err = 1'b1;
                            else retry = 1'b1;
                        end
                    endcase
                    state_nx = retry ? S_ARB : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        HReq        = start | (state == S_ARB) | (state == S_ADDR);
        HLock       = 1'b0;
        HTrans      = '0;
        HAddress    = '0;
        HSize       = '0;
        HWrite      = 1'b0;
        HWrite_data = '0;
        if (state == S_ADDR) begin
            HTrans   = 2'b10;
            HAddress = {SEL, x_addr};
            HSize    = x_size;
            HWrite   = x_write;
        end
        if (state == S_DATA && x_write) HWrite_data = x_data;
    end

    assign wbuf_empty = rst & f_empty & ~((state != S_IDLE) & x_write);
    assign cpu_rvalid = rvalid_q;
    assign cpu_err    = err_q;
    assign cpu_rdata  = rdata_q;

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr[AW-1:0]] <= cpu_addr[27:0];
            f_size[wr_ptr[AW-1:0]] <= cpu_size;
            f_data[wr_ptr[AW-1:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
            rd_size   <= '0;
            x_write   <= 1'b0;
            x_addr    <= '0;
            x_size    <= '0;
            x_data    <= '0;
            retry_cnt <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state    <= state_nx;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // Oversized requests never reach the bus; they just bounce an error.
            if (cpu_ack && size_bad) begin
                err_q    <= 1'b1;
                rvalid_q <= ~cpu_write;
            end
            if (cpu_ack && !cpu_write && !size_bad) begin
                rd_pend <= 1'b1;
                rd_addr <= cpu_addr[27:0];
                rd_size <= cpu_size;
            end
            if (start) begin
                retry_cnt <= '0;
                if (!f_empty) begin
                    x_write <= 1'b1;
                    x_addr  <= f_addr[rd_ptr[AW-1:0]];
                    x_size  <= f_size[rd_ptr[AW-1:0]];
                    x_data  <= f_data[rd_ptr[AW-1:0]];
                end else begin
                    x_write <= 1'b0;
                    x_addr  <= rd_addr;
                    x_size  <= rd_size;
                    x_data  <= '0;
                end
            end
            if (retry) retry_cnt <= retry_cnt + 1'b1;
            if ((done_ok || done_err) && !x_write) begin
                rd_pend  <= 1'b0;
                rvalid_q <= 1'b1;
                rdata_q  <= done_ok ? HRead_data : '0;
            end
            if (done_err) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb_master_bridge.sv
// Scoreboard bench for ahb_master_bridge: directed CPU traffic, a scripted
// AHB slave, and monitors that pop expected bus/CPU events as they appear.
module tb_ahb_master_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_write;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_ack, cpu_rvalid, cpu_err, wbuf_empty;
    logic [31:0] cpu_rdata;
    logic        HReq, HLock, HWrite;
    logic [31:0] HAddress, HWrite_data;
    logic [1:0]  HTrans;
    logic [2:0]  HSize;
    logic [31:0] HRead_data;
    logic [1:0]  HResp;
    logic        HReady, HGrant;

    ahb_master_bridge #(
        .SEL(4'h2), .DW(32), .WBUF_DEPTH(2), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .wbuf_empty(wbuf_empty),
        .HReq(HReq), .HLock(HLock), .HAddress(HAddress), .HTrans(HTrans),
        .HSize(HSize), .HWrite(HWrite), .HWrite_data(HWrite_data),
        .HRead_data(HRead_data), .HResp(HResp), .HReady(HReady),
        .HGrant(HGrant)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; logic wr; logic [2:0] size;} bus_t;
    typedef struct packed {logic rv; logic err; logic [31:0] data;} rsp_t;
    typedef struct packed {logic [7:0] waits; logic [1:0] resp; logic [31:0] data;} slv_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_wd[$];
    rsp_t        exp_rsp[$];
    slv_t        slv_q[$];

    int checks = 0;
    int errors = 0;
    int wd_done = 0;
    logic dp_start = 1'b0;
    logic in_dph = 1'b0;
    logic dp_wr = 1'b0;

    wire [107:0] all_outs = {cpu_ack, cpu_rvalid, cpu_rdata, cpu_err, wbuf_empty,
                             HReq, HLock, HAddress, HTrans, HSize, HWrite, HWrite_data};

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Bus and CPU-side monitor
    always @(negedge clk) begin
        dp_start = 1'b0;
        if (!rst) begin
            in_dph = 1'b0;
        end else begin
            if (in_dph && HReady) begin
                chk("data_phase_htrans", HTrans, 2'b00);
                if (dp_wr) begin
                    if (exp_wd.size() == 0) chk("unexpected_wdata", 1'b1, 1'b0);
                    else chk("hwrite_data", HWrite_data, exp_wd.pop_front());
                    wd_done++;
                end
                in_dph = 1'b0;
            end
            if (HTrans == 2'b10 && HReady) begin
                if (exp_bus.size() == 0) chk("unexpected_addr_phase", HAddress, 32'h0);
                else chk("addr_phase", {HAddress, HWrite, HSize}, exp_bus.pop_front());
                dp_start = 1'b1;
                in_dph   = 1'b1;
                dp_wr    = HWrite;
            end
            if (cpu_rvalid || cpu_err) begin
                if (exp_rsp.size() == 0) chk("unexpected_rsp", {cpu_rvalid, cpu_err}, 2'b00);
                else chk("cpu_rsp", {cpu_rvalid, cpu_err, cpu_rdata}, exp_rsp.pop_front());
            end
        end
    end

    // Scripted slave: one entry per data phase, default is zero-wait OKAY
    initial begin
        slv_t cur;
        int   wleft;
        logic busy;
        busy = 1'b0;
        wleft = 0;
        cur = '0;
        HReady = 1'b1;
        HResp = 2'b00;
        HRead_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                busy = 1'b0;
                HReady = 1'b1;
                HResp = 2'b00;
                HRead_data = '0;
            end else begin
                if (dp_start) begin
                    cur = (slv_q.size() != 0) ? slv_q.pop_front() : '0;
                    wleft = int'(cur.waits);
                    busy = 1'b1;
                end
                if (busy) begin
                    if (wleft > 0) begin
                        HReady = 1'b0;
                        HResp = (cur.resp == 2'b01) ? 2'b01 : 2'b00;
                        HRead_data = '0;
                        wleft--;
                    end else begin
                        HReady = 1'b1;
                        HResp = cur.resp;
                        HRead_data = cur.data;
                        busy = 1'b0;
                    end
                end else begin
                    HReady = 1'b1;
                    HResp = 2'b00;
                    HRead_data = '0;
                end
            end
        end
    end

    task automatic cpu_op(input string nm, input logic w, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cpu_req = 1'b1;
        cpu_write = w;
        cpu_size = sz;
        cpu_addr = a;
        cpu_wdata = d;
        @(negedge clk);
        while (!cpu_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, cpu_ack, 1'b1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_bus.size() == 0 && exp_wd.size() == 0 && exp_rsp.size() == 0 &&
                     wbuf_empty && !HReq) && n < 400);
        chk(nm, n < 400, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        int   base;
        logic stalled;
        rst = 1'b0;
        cpu_req = 1'b0;
        cpu_write = 1'b0;
        cpu_size = 3'd2;
        cpu_addr = '0;
        cpu_wdata = '0;
        HGrant = 1'b1;

        // Reset state, with a request held to show cpu_ack is masked
        repeat (3) @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_write = 1'b1;
        #1;
        chk("reset_outputs", all_outs, 108'h0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_wbuf_empty", wbuf_empty, 1'b1);
        chk("post_reset_hreq", HReq, 1'b0);
        @(posedge clk);
        #1;

        // Single write: ack same cycle, HReq next cycle, SEL region applied
        exp_bus.push_back('{32'h2000_0104, 1'b1, 3'd2});
        exp_wd.push_back(32'hDEAD_BEEF);
        cpu_req = 1'b1;
        cpu_write = 1'b1;
        cpu_size = 3'd2;
        cpu_addr = 32'h0000_0104;
        cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_ack_same_cycle", cpu_ack, 1'b1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("t2_hreq_next_cycle", HReq, 1'b1);
        wait_done("t2_drain");

        // Asynchronous reset in the middle of a stretched data phase
        exp_bus.push_back('{32'h2000_0200, 1'b1, 3'd2});
        slv_q.push_back('{8'd6, 2'b00, 32'h0});
        cpu_op("t1_ack", 1'b1, 3'd2, 32'hF000_0200, 32'hA5A5_0001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (HWrite_data == 32'h0 && n < 50);
        chk("t1_reach_data_phase", HWrite_data, 32'hA5A5_0001);
        #2;
        rst = 1'b0;
        #1;
        chk("t1_async_reset_outputs", all_outs, 108'h0);
        exp_wd.delete();
        slv_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("t1_after_reset_empty", {wbuf_empty, HReq}, 2'b10);
        @(posedge clk);
        #1;

        // Two-entry FIFO fills while the grant is withheld
        HGrant = 1'b0;
        exp_bus.push_back('{32'h2000_0010, 1'b1, 3'd2});
        exp_bus.push_back('{32'h2000_0014, 1'b1, 3'd2});
        exp_bus.push_back('{32'h2000_0018, 1'b1, 3'd2});
        exp_wd.push_back(32'h1111_1111);
        exp_wd.push_back(32'h2222_2222);
        exp_wd.push_back(32'h3333_3333);
        cpu_op("t3_ack_a", 1'b1, 3'd2, 32'h0000_0010, 32'h1111_1111);
        cpu_op("t3_ack_b", 1'b1, 3'd2, 32'h0000_0014, 32'h2222_2222);
        cpu_req = 1'b1;
        cpu_addr = 32'h0000_0018;
        cpu_wdata = 32'h3333_3333;
        stalled = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack) stalled = 1'b0;
        end
        chk("t3_c_stalls_when_full", stalled, 1'b1);
        @(posedge clk);
        #1;
        base = wd_done;
        HGrant = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 100);
        chk("t3_c_ack", cpu_ack, 1'b1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        chk("t3_c_after_a_pop", wd_done - base, 1);
        wait_done("t3_drain");

        // Read waits behind the write, then three wait states
        exp_bus.push_back('{32'h2000_0080, 1'b1, 3'd2});
        exp_bus.push_back('{32'h2000_0040, 1'b0, 3'd2});
        exp_wd.push_back(32'hCAFE_F00D);
        slv_q.push_back('{8'd0, 2'b00, 32'h0});
        slv_q.push_back('{8'd3, 2'b00, 32'h1234_5678});
        exp_rsp.push_back('{1'b1, 1'b0, 32'h1234_5678});
        cpu_op("t4_ack_w", 1'b1, 3'd2, 32'h0000_0080, 32'hCAFE_F00D);
        cpu_op("t4_ack_r", 1'b0, 3'd2, 32'h0000_0040, 32'h0);
        cpu_req = 1'b1;
        cpu_write = 1'b1;
        @(negedge clk);
        chk("t4_refuse_while_rd_pend", cpu_ack, 1'b0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        wait_done("t4_drain");

        // RETRY twice then OKAY on a write
        repeat (3) begin
            exp_bus.push_back('{32'h2000_0300, 1'b1, 3'd2});
            exp_wd.push_back(32'h5555_AAAA);
        end
        slv_q.push_back('{8'd0, 2'b10, 32'h0});
        slv_q.push_back('{8'd0, 2'b11, 32'h0});
        slv_q.push_back('{8'd0, 2'b00, 32'h0});
        cpu_op("t5a_ack", 1'b1, 3'd2, 32'h0000_0300, 32'h5555_AAAA);
        wait_done("t5a_drain");

        // RETRY four times on a read exhausts the budget
        repeat (4) begin
            exp_bus.push_back('{32'h2000_0304, 1'b0, 3'd2});
            slv_q.push_back('{8'd0, 2'b10, 32'h9999_9999});
        end
        exp_rsp.push_back('{1'b1, 1'b1, 32'h0});
        cpu_op("t5b_ack", 1'b0, 3'd2, 32'h0000_0304, 32'h0);
        wait_done("t5b_drain");

        // Two-cycle ERROR on a read, then a clean read
        exp_bus.push_back('{32'h2000_0308, 1'b0, 3'd2});
        slv_q.push_back('{8'd1, 2'b01, 32'hFFFF_FFFF});
        exp_rsp.push_back('{1'b1, 1'b1, 32'h0});
        cpu_op("t6_ack_err_rd", 1'b0, 3'd2, 32'h0000_0308, 32'h0);
        wait_done("t6_drain_err");
        exp_bus.push_back('{32'h2000_030C, 1'b0, 3'd2});
        slv_q.push_back('{8'd0, 2'b00, 32'h0BAD_CAFE});
        exp_rsp.push_back('{1'b1, 1'b0, 32'h0BAD_CAFE});
        cpu_op("t6_next_read_ack", 1'b0, 3'd2, 32'h0000_030C, 32'h0);
        wait_done("t6_drain_ok");

        // Write ERROR, byte-size write, oversized write and read
        exp_bus.push_back('{32'h2000_0400, 1'b1, 3'd2});
        exp_wd.push_back(32'h7777_0000);
        slv_q.push_back('{8'd1, 2'b01, 32'h0});
        exp_rsp.push_back('{1'b0, 1'b1, 32'h0});
        cpu_op("t7_ack_err_wr", 1'b1, 3'd2, 32'h0000_0400, 32'h7777_0000);
        wait_done("t7_drain_err_wr");
        exp_bus.push_back('{32'h2000_0501, 1'b1, 3'd0});
        exp_wd.push_back(32'h0000_00AB);
        cpu_op("t7_ack_byte", 1'b1, 3'd0, 32'h0000_0501, 32'h0000_00AB);
        wait_done("t7_drain_byte");
        exp_rsp.push_back('{1'b0, 1'b1, 32'h0});
        cpu_op("t7_ack_bad_wr", 1'b1, 3'd3, 32'h0000_0600, 32'h1);
        exp_rsp.push_back('{1'b1, 1'b1, 32'h0});
        cpu_op("t7_ack_bad_rd", 1'b0, 3'd3, 32'h0000_0604, 32'h0);
        wait_done("t7_drain_bad");

        repeat (5) @(negedge clk);
        chk("end_exp_bus_empty", exp_bus.size(), 0);
        chk("end_exp_wd_empty", exp_wd.size(), 0);
        chk("end_exp_rsp_empty", exp_rsp.size(), 0);
        chk("end_slave_script_empty", slv_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
